// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Main control state machine of the multi-cycle RV32I core. Every instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and back to FETCH. Unknown
// opcodes park the machine in TRAP until the next reset.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   opcode               IR[6:0] of the latched instruction
//   imem_ready           instruction memory has data (used in FETCH only)
//   dmem_ready           data access completes (used in MEM only)
//   imem_req, ir_write   fetch request / IR latch enable
//   dmem_req, dmem_we    data access request / store enable
//   reg_write, wb_sel    register write enable / 0 = ALU, 1 = memory data
//   alu_src_a/b, alu_op  datapath selects
//   pc_write, branch,
//   pcsrc, pcsrc2        PC update strobes, consumed on the same clock edge
//   illegal_instr        sticky trap flag
//   state                current state (debug)
//   instret              retired-instruction counter (wraps)
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             branch,
  output logic             pcsrc,
  output logic             pcsrc2,
  output logic             illegal_instr,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_R      = 4'd0,
    CL_I      = 4'd1,
    CL_LOAD   = 4'd2,
    CL_STORE  = 4'd3,
    CL_BRANCH = 4'd4,
    CL_JAL    = 4'd5,
    CL_JALR   = 4'd6,
    CL_LUI    = 4'd7,
    CL_AUIPC  = 4'd8,
    CL_ILL    = 4'd9
  } class_t;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = CL_R;
      7'b0010011: decode_class = CL_I;
      7'b0000011: decode_class = CL_LOAD;
      7'b0100011: decode_class = CL_STORE;
      7'b1100011: decode_class = CL_BRANCH;
      7'b1101111: decode_class = CL_JAL;
      7'b1100111: decode_class = CL_JALR;
      7'b0110111: decode_class = CL_LUI;
      7'b0010111: decode_class = CL_AUIPC;
      default:    decode_class = CL_ILL;
    endcase
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  class_t           class_r;
  class_t           decoded_s;
  logic             illegal_r;
  logic [CNT_W-1:0] instret_r;

  logic       imem_req_s, ir_write_s, dmem_req_s, dmem_we_s;
  logic       reg_write_s, wb_sel_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, alu_op_s;
  logic       pc_write_s, branch_s, pcsrc_s, pcsrc2_s;

  assign decoded_s = decode_class(opcode);

  // Next-state and raw (ungated) control outputs from state, class and readies.
  always_comb begin
    next_state_s = state_r;
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    reg_write_s  = 1'b0;
    wb_sel_s     = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    pcsrc_s      = 1'b0;
    pcsrc2_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_write_s   = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC + imm is precomputed here for branch/jump targets.
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b01;
        if (decoded_s == CL_ILL) begin
          next_state_s = S_TRAP;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        next_state_s = S_WB;
        case (class_r)
          CL_R: begin
            alu_op_s = 2'b10;
          end
          CL_I: begin
            alu_src_b_s = 2'b01;
            alu_op_s    = 2'b10;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b_s  = 2'b01;
            next_state_s = S_MEM;
          end
          CL_LUI: begin
            alu_src_b_s = 2'b01;
            alu_op_s    = 2'b11;
          end
          CL_AUIPC: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b01;
          end
          CL_JAL, CL_JALR: begin
            // Link value PC + 4.
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
          end
          CL_BRANCH: begin
            // The PC adder only takes the offset when its zero flag is set.
            alu_op_s     = 2'b01;
            branch_s     = 1'b1;
            pc_write_s   = 1'b1;
            next_state_s = S_FETCH;
          end
          default: begin
            next_state_s = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (class_r == CL_STORE);
        if (!dmem_ready) begin
          next_state_s = S_MEM;
        end else if (class_r == CL_STORE) begin
          pc_write_s   = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        wb_sel_s     = (class_r == CL_LOAD);
        pc_write_s   = 1'b1;
        pcsrc_s      = (class_r == CL_JAL);
        pcsrc2_s     = (class_r == CL_JALR);
        next_state_s = S_FETCH;
      end
      S_TRAP: begin
        next_state_s = S_TRAP;
      end
      default: begin
        next_state_s = S_TRAP;
      end
    endcase
  end

  // State, latched opcode class, sticky trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      class_r   <= CL_R;
      illegal_r <= 1'b0;
      instret_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        class_r <= decoded_s;
      end else begin
        class_r <= class_r;
      end
      if (next_state_s == S_TRAP) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
      if (pc_write_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Outputs are forced low while reset is held so a pending request drops at once.
  assign imem_req      = rst_n & imem_req_s;
  assign ir_write      = rst_n & ir_write_s;
  assign dmem_req      = rst_n & dmem_req_s;
  assign dmem_we       = rst_n & dmem_we_s;
  assign reg_write     = rst_n & reg_write_s;
  assign wb_sel        = rst_n & wb_sel_s;
  assign alu_src_a     = rst_n & alu_src_a_s;
  assign alu_src_b     = {2{rst_n}} & alu_src_b_s;
  assign alu_op        = {2{rst_n}} & alu_op_s;
  assign pc_write      = rst_n & pc_write_s;
  assign branch        = rst_n & branch_s;
  assign pcsrc         = rst_n & pcsrc_s;
  assign pcsrc2        = rst_n & pcsrc2_s;
  assign illegal_instr = illegal_r;
  assign state         = state_r;
  assign instret       = instret_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks each instruction class through
// the FSM and compares state plus a packed vector of all control outputs
// against hand-written expectations.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        pc_write, branch, pcsrc, pcsrc2, illegal_instr;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [15:0] outv;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ILL   = 7'b1110011;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .branch(branch), .pcsrc(pcsrc), .pcsrc2(pcsrc2),
    .illegal_instr(illegal_instr), .state(state), .instret(instret)
  );

  assign outv = {imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel,
                 alu_src_a, alu_src_b, alu_op, pc_write, branch, pcsrc,
                 pcsrc2, illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mk(
    input logic irq, input logic irw, input logic drq, input logic dwe,
    input logic rw, input logic wbs, input logic a, input logic [1:0] b,
    input logic [1:0] op, input logic pcw, input logic br, input logic ps,
    input logic ps2, input logic ill);
    mk = {irq, irw, drq, dwe, rw, wbs, a, b, op, pcw, br, ps, ps2, ill};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then check state and outputs.
  task automatic cyc(input string tag, input logic rst, input logic ir,
                     input logic dr, input logic [6:0] opc,
                     input logic [2:0] st, input logic [15:0] v);
    @(negedge clk);
    rst_n      = rst;
    imem_ready = ir;
    dmem_ready = dr;
    opcode     = opc;
    #1;
    check_val({tag, "_state"}, {29'd0, state}, {29'd0, st});
    check_val({tag, "_outs"}, {16'd0, outv}, {16'd0, v});
  endtask

  logic [15:0] v_zero, v_frdy, v_fwait, v_dec, v_ex_r, v_wb_r, v_ex_br;
  logic [15:0] v_ex_ls, v_mem_l, v_wb_l, v_mem_s, v_mem_s_rdy;
  logic [15:0] v_ex_j, v_wb_jal, v_wb_jalr, v_trap;

  initial begin
    v_zero      = 16'd0;
    v_frdy      = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_fwait     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_dec       = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_ex_r      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_wb_r      = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0);
    v_ex_br     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b1,1'b0,1'b0,1'b0);
    v_ex_ls     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_mem_l     = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_wb_l      = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0);
    v_mem_s     = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_mem_s_rdy = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0);
    v_ex_j      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0);
    v_wb_jal    = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0);
    v_wb_jalr   = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0);
    v_trap      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1);

    rst_n      = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    opcode     = OP_R;

    // Reset held three cycles with a ready fetch pending.
    for (int i = 0; i < 3; i++) cyc("rst", 1'b0, 1'b1, 1'b0, OP_R, 3'd0, v_zero);
    check_val("rst_instret", instret, 32'd0);

    // R-type: FETCH, DECODE, EXEC, WB.
    cyc("r_fetch", 1'b1, 1'b1, 1'b0, OP_R, 3'd0, v_frdy);
    cyc("r_dec",   1'b1, 1'b1, 1'b0, OP_R, 3'd1, v_dec);
    cyc("r_exec",  1'b1, 1'b1, 1'b0, OP_R, 3'd2, v_ex_r);
    cyc("r_wb",    1'b1, 1'b1, 1'b0, OP_R, 3'd4, v_wb_r);

    // Branch: three cycles, resolves in EXEC.
    cyc("b_fetch", 1'b1, 1'b1, 1'b1, OP_BR, 3'd0, v_frdy);
    check_val("r_instret", instret, 32'd1);
    cyc("b_dec",   1'b1, 1'b1, 1'b1, OP_BR, 3'd1, v_dec);
    cyc("b_exec",  1'b1, 1'b1, 1'b1, OP_BR, 3'd2, v_ex_br);

    // Load with four wait cycles in MEM.
    cyc("l_fetch", 1'b1, 1'b1, 1'b0, OP_LOAD, 3'd0, v_frdy);
    check_val("b_instret", instret, 32'd2);
    cyc("l_dec",   1'b1, 1'b1, 1'b0, OP_LOAD, 3'd1, v_dec);
    cyc("l_exec",  1'b1, 1'b1, 1'b0, OP_LOAD, 3'd2, v_ex_ls);
    for (int i = 0; i < 4; i++) cyc("l_memw", 1'b1, 1'b1, 1'b0, OP_LOAD, 3'd3, v_mem_l);
    cyc("l_memr",  1'b1, 1'b1, 1'b1, OP_LOAD, 3'd3, v_mem_l);
    cyc("l_wb",    1'b1, 1'b1, 1'b0, OP_LOAD, 3'd4, v_wb_l);

    // Store: pc_write with dmem_ready, straight back to FETCH.
    cyc("s_fetch", 1'b1, 1'b1, 1'b0, OP_STORE, 3'd0, v_frdy);
    check_val("l_instret", instret, 32'd3);
    cyc("s_dec",   1'b1, 1'b1, 1'b0, OP_STORE, 3'd1, v_dec);
    cyc("s_exec",  1'b1, 1'b1, 1'b0, OP_STORE, 3'd2, v_ex_ls);
    cyc("s_memw",  1'b1, 1'b1, 1'b0, OP_STORE, 3'd3, v_mem_s);
    cyc("s_memr",  1'b1, 1'b1, 1'b1, OP_STORE, 3'd3, v_mem_s_rdy);

    // JAL then JALR.
    cyc("j_fetch", 1'b1, 1'b1, 1'b0, OP_JAL, 3'd0, v_frdy);
    check_val("s_instret", instret, 32'd4);
    cyc("j_dec",   1'b1, 1'b1, 1'b0, OP_JAL, 3'd1, v_dec);
    cyc("j_exec",  1'b1, 1'b1, 1'b0, OP_JAL, 3'd2, v_ex_j);
    cyc("j_wb",    1'b1, 1'b1, 1'b0, OP_JAL, 3'd4, v_wb_jal);
    cyc("jr_fetch",1'b1, 1'b1, 1'b0, OP_JALR, 3'd0, v_frdy);
    cyc("jr_dec",  1'b1, 1'b1, 1'b0, OP_JALR, 3'd1, v_dec);
    cyc("jr_exec", 1'b1, 1'b1, 1'b0, OP_JALR, 3'd2, v_ex_j);
    cyc("jr_wb",   1'b1, 1'b1, 1'b0, OP_JALR, 3'd4, v_wb_jalr);

    // Fetch stall, then an illegal opcode into TRAP for 20 cycles.
    cyc("i_wait",  1'b1, 1'b0, 1'b0, OP_ILL, 3'd0, v_fwait);
    check_val("j_instret", instret, 32'd6);
    cyc("i_fetch", 1'b1, 1'b1, 1'b0, OP_ILL, 3'd0, v_frdy);
    cyc("i_dec",   1'b1, 1'b1, 1'b0, OP_ILL, 3'd1, v_dec);
    for (int i = 0; i < 20; i++) cyc("trap", 1'b1, 1'b1, 1'b1, OP_R, 3'd7, v_trap);
    check_val("trap_instret", instret, 32'd6);
    cyc("trap_rst", 1'b0, 1'b1, 1'b1, OP_R, 3'd0, v_zero);
    check_val("trap_rst_instret", instret, 32'd0);

    // Load interrupted by reset while waiting in MEM.
    cyc("m_fetch", 1'b1, 1'b1, 1'b0, OP_LOAD, 3'd0, v_frdy);
    cyc("m_dec",   1'b1, 1'b1, 1'b0, OP_LOAD, 3'd1, v_dec);
    cyc("m_exec",  1'b1, 1'b1, 1'b0, OP_LOAD, 3'd2, v_ex_ls);
    cyc("m_memw",  1'b1, 1'b1, 1'b0, OP_LOAD, 3'd3, v_mem_l);
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check_val("m_async_dreq", {31'd0, dmem_req}, 32'd0);
    check_val("m_async_state", {29'd0, state}, 32'd0);
    cyc("m_rst",   1'b0, 1'b0, 1'b1, OP_LOAD, 3'd0, v_zero);
    cyc("m_rel",   1'b1, 1'b0, 1'b1, OP_LOAD, 3'd0, v_fwait);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
